s4ga_cfg_seq: RTL

- Configuration sequencer for the s4ga LUT fabric.
- Fetches the LUT configuration image byte-wise from an external config memory, buffers it in a small FIFO, and drives the fabric's 4-bit segment stream (si) at exactly one segment per clock, looping the image once per sweep.
- Owns the fabric reset: holds it for a full initialisation period, and re-asserts it on underflow or stop.

---
 rtl/s4ga_cfg_seq_if.sv | 13 +
 rtl/s4ga_cfg_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/s4ga_cfg_seq_if.sv
// Config-memory read port of the s4ga configuration sequencer.
// One request outstanding at most; mem_ack is a one-cycle acknowledge carrying mem_rdata.
interface s4ga_cfg_seq_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/s4ga_cfg_seq.sv
// s4ga LUT-fabric configuration sequencer: byte fetch -> FIFO -> 4-bit segment stream.
// Optional S4GA_CFG_SEQ_SUM_EN adds sweep_sum (mod-256 sum of bytes popped in the last sweep).
module s4ga_cfg_seq #(
  parameter int N            = 79,
  parameter int SEGS_PER_LUT = 18,
  parameter int ADDR_W       = 16,
  parameter int FIFO_D       = 8,
  parameter int RST_CYC      = 81
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  s4ga_cfg_seq_if.master        mem,
  output logic                  fab_rst,
  output logic [3:0]            fab_si,
  output logic                  running,
  output logic                  sweep_done,
  output logic [15:0]           sweep_cnt,
  output logic                  err
`ifdef S4GA_CFG_SEQ_SUM_EN
  ,
  output logic [7:0]            sweep_sum
`endif
);

  localparam int IMG_B = N * SEGS_PER_LUT / 2;
  localparam int SEGS  = N * SEGS_PER_LUT;
  localparam int PW    = $clog2(FIFO_D);
  localparam int SW    = $clog2(SEGS);
  localparam int RW    = $clog2(RST_CYC);

  localparam logic [PW:0]       CNT_MAX   = (PW+1)'(FIFO_D);
  localparam logic [SW-1:0]     SEG_LAST  = SW'(SEGS - 1);
  localparam logic [SW-1:0]     SEG_PEN   = SW'(SEGS - 2);
  localparam logic [RW-1:0]     RC_LAST   = RW'(RST_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_B - 1);

  typedef enum logic [1:0] {IDLE, PRELOAD, RUN} state_t;

  state_t            state, state_d;
  logic [7:0]        fifo [FIFO_D];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              pend, disc;
  logic [ADDR_W-1:0] addr;
  logic [RW-1:0]     rc;
  logic [SW-1:0]     seg;
  logic              ph, stop_req;

  logic       ack_v, fifo_full, rst_done, underflow, flush, issue, push, pop;
  logic       fab_rst_d;
  logic [3:0] fab_si_d;
  logic [7:0] head;

  assign head      = fifo[rd_ptr];
  assign ack_v     = mem.mem_ack & pend;
  assign fifo_full = (count == CNT_MAX) && !pend;
  assign rst_done  = (rc >= RC_LAST);
  // ph=1: the next edge is due to emit a high nibble, so the head byte must already be present
  assign underflow = (state == RUN) && ph && (count == '0);
  assign flush     = (state == IDLE) || underflow || (state == PRELOAD && !en);
  assign issue     = (state == PRELOAD || state == RUN) && !flush && !pend && (count < CNT_MAX);
  assign push      = ack_v && !disc && !flush;

  assign mem.mem_req  = pend;
  assign mem.mem_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (en) state_d = PRELOAD;
      PRELOAD: begin
        if (!en)                       state_d = IDLE;
        else if (rst_done && fifo_full) state_d = RUN;
      end
      RUN: begin
        if (underflow)                   state_d = PRELOAD;
        else if (sweep_done && stop_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fab_rst_d = 1'b1;
    fab_si_d  = '0;
    pop       = 1'b0;
    running   = (state == RUN);
    if (state_d == RUN) begin
      fab_rst_d = 1'b0;
      if (state == RUN && !ph) begin
        fab_si_d = head[3:0];
        pop      = 1'b1;
      end else begin
        fab_si_d = head[7:4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      disc       <= 1'b0;
      addr       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rc         <= '0;
      seg        <= '0;
      ph         <= 1'b0;
      stop_req   <= 1'b0;
      fab_rst    <= 1'b1;
      fab_si     <= '0;
      sweep_done <= 1'b0;
      sweep_cnt  <= '0;
      err        <= 1'b0;
    end else begin
      fab_rst  <= fab_rst_d;
      fab_si   <= fab_si_d;
      stop_req <= (state == RUN) && !en;

      // A request caught by a flush is still completed, but its data is dropped
      // and the address rewinds only once the bus is free again.
      if (ack_v) begin
        pend <= 1'b0;
        disc <= 1'b0;
        addr <= (disc || flush || addr == ADDR_LAST) ? '0 : addr + 1'b1;
      end else if (flush) begin
        if (pend) disc <= 1'b1;
        else      addr <= '0;
      end else if (issue) begin
        pend <= 1'b1;
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end

      if (state != PRELOAD) rc <= '0;
      else if (!rst_done)   rc <= rc + 1'b1;

      if (state == IDLE && en) sweep_cnt <= '0;

      sweep_done <= 1'b0;
      if (state != RUN) begin
        seg <= '0;
        ph  <= 1'b0;
      end else if (state_d == RUN) begin
        ph  <= ~ph;
        seg <= (seg == SEG_LAST) ? '0 : seg + 1'b1;
        if (seg == SEG_PEN) begin
          sweep_done <= 1'b1;
          sweep_cnt  <= sweep_cnt + 1'b1;
        end
      end

      if (underflow) err <= 1'b1;
    end
  end

`ifdef S4GA_CFG_SEQ_SUM_EN
  logic [7:0] acc;

  // The last byte of a sweep pops on the same edge that raises sweep_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sweep_sum <= '0;
    end else if (state == IDLE || underflow) begin
      acc <= '0;
    end else if (pop) begin
      if (seg == SEG_PEN) begin
        sweep_sum <= acc + head;
        acc       <= '0;
      end else begin
        acc <= acc + head;
      end
    end
  end
`endif

endmodule
